// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the CPU data-memory port.
// Accepts one load/store per handshake, issues word-aligned req/ack memory
// transactions (two for accesses that cross a word boundary), aligns and
// extends load data, and reports completion with a one-cycle done pulse.
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,   // only 32 (four byte lanes) is supported
    parameter int ACK_TIMEOUT   = 16    // 0 = wait forever for mem_ack_i
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    output logic                     ready_o,
    input  logic                     we_i,
    input  logic [2:0]               funct3_i,
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    output logic                     done_o,
    output logic                     err_o,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [3:0]               mem_be_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
    input  logic                     mem_ack_i
);

    localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state_reg, state_next;
    logic                     we_reg, we_next;
    logic [2:0]               funct3_reg, funct3_next;
    logic [ADDRESS_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]    wdata_reg, wdata_next;
    logic                     err_reg, err_next;
    logic [DATA_WIDTH-1:0]    rdata0_reg, rdata0_next;
    logic [DATA_WIDTH-1:0]    data_reg, data_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;

    logic [7:0]               base_mask;
    logic [7:0]               mask8;
    logic                     split;
    logic [4:0]               byte_shift;
    logic [2*DATA_WIDTH-1:0]  w64;
    logic [DATA_WIDTH-1:0]    rdata_lo;
    logic [DATA_WIDTH-1:0]    rdata_hi;
    logic [2*DATA_WIDTH-1:0]  r64_shifted;
    logic [DATA_WIDTH-1:0]    load_raw;
    logic [DATA_WIDTH-1:0]    load_result;
    logic [ADDRESS_WIDTH-1:0] word_addr;
    logic                     timeout_hit;
    logic                     illegal_in;

    // Illegal width codes: reserved encodings, and unsigned widths on stores.
    assign illegal_in = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) ||
                        (we_i && funct3_i[2]);

    // Lane mask over two consecutive words; bits [7:4] belong to the second word.
    always_comb begin
        base_mask = 8'h0F;
        case (funct3_reg[1:0])
            2'b00:   base_mask = 8'h01;
            2'b01:   base_mask = 8'h03;
            default: base_mask = 8'h0F;
        endcase
    end

    assign byte_shift = {addr_reg[1:0], 3'b000};
    assign mask8      = base_mask << addr_reg[1:0];
    assign split      = |mask8[7:4];
    assign w64        = {{DATA_WIDTH{1'b0}}, wdata_reg} << byte_shift;
    assign word_addr  = {addr_reg[ADDRESS_WIDTH-1:2], 2'b00};

    // The abort fires at the end of the ACK_TIMEOUT-th consecutive non-ack cycle.
    assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_reg == CNT_W'(ACK_TIMEOUT - 1));

    // Assemble the two-word read window for the beat that completes the load.
    always_comb begin
        rdata_lo = mem_rdata_i;
        rdata_hi = '0;
        if (state_reg == ACC1) begin
            rdata_lo = rdata0_reg;
            rdata_hi = mem_rdata_i;
        end
    end

    assign r64_shifted = {rdata_hi, rdata_lo} >> byte_shift;
    assign load_raw    = r64_shifted[DATA_WIDTH-1:0];

    // Sign- or zero-extend the aligned load value according to the width code.
    always_comb begin
        load_result = load_raw;
        case (funct3_reg)
            3'b000:  load_result = {{(DATA_WIDTH-8){load_raw[7]}}, load_raw[7:0]};
            3'b001:  load_result = {{(DATA_WIDTH-16){load_raw[15]}}, load_raw[15:0]};
            3'b100:  load_result = {{(DATA_WIDTH-8){1'b0}}, load_raw[7:0]};
            3'b101:  load_result = {{(DATA_WIDTH-16){1'b0}}, load_raw[15:0]};
            default: load_result = load_raw;
        endcase
    end

    // Next-state logic and memory-port outputs.
    always_comb begin
        state_next  = state_reg;
        we_next     = we_reg;
        funct3_next = funct3_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        err_next    = err_reg;
        rdata0_next = rdata0_reg;
        data_next   = data_reg;
        cnt_next    = cnt_reg;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = 4'b0000;
        mem_wdata_o = '0;

        case (state_reg)
            IDLE: begin
                if (req_i) begin
                    we_next     = we_i;
                    funct3_next = funct3_i;
                    addr_next   = addr_i;
                    wdata_next  = data_i;
                    cnt_next    = '0;
                    if (illegal_in) begin
                        err_next   = 1'b1;
                        data_next  = '0;
                        state_next = DONE;
                    end else begin
                        err_next   = 1'b0;
                        state_next = ACC0;
                    end
                end
            end

            ACC0, ACC1: begin
                mem_req_o = 1'b1;
                mem_we_o  = we_reg;
                if (state_reg == ACC0) begin
                    mem_addr_o  = word_addr;
                    mem_be_o    = mask8[3:0];
                    mem_wdata_o = w64[DATA_WIDTH-1:0];
                end else begin
                    mem_addr_o  = word_addr + ADDRESS_WIDTH'(4);
                    mem_be_o    = mask8[7:4];
                    mem_wdata_o = w64[2*DATA_WIDTH-1:DATA_WIDTH];
                end

                if (mem_ack_i) begin
                    if (state_reg == ACC0 && split) begin
                        if (!we_reg) begin
                            rdata0_next = mem_rdata_i;
                        end
                        cnt_next   = '0;
                        state_next = ACC1;
                    end else begin
                        data_next  = we_reg ? '0 : load_result;
                        state_next = DONE;
                    end
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    data_next  = '0;
                    state_next = DONE;
                end else if (ACK_TIMEOUT != 0) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ready_o = (state_reg == IDLE);
    assign done_o  = (state_reg == DONE);
    assign err_o   = (state_reg == DONE) && err_reg;
    assign data_o  = data_reg;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            err_reg    <= 1'b0;
            rdata0_reg <= '0;
            data_reg   <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            we_reg     <= we_next;
            funct3_reg <= funct3_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            err_reg    <= err_next;
            rdata0_reg <= rdata0_next;
            data_reg   <= data_next;
            cnt_reg    <= cnt_next;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural req/ack responder.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        ready_o;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        done_o;
    logic        err_o;
    logic [31:0] data_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Responder controls and request log
    int          ack_wait = 0;
    int          acks_allowed = 1000000;
    int          wait_cnt = 0;
    logic        new_req = 1'b1;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] log_addr[$];
    logic [3:0]  log_be[$];
    logic [31:0] log_wdata[$];
    logic        log_we[$];

    load_store_unit #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .ACK_TIMEOUT  (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .ready_o    (ready_o),
        .we_i       (we_i),
        .funct3_i   (funct3_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .done_o     (done_o),
        .err_o      (err_o),
        .data_o     (data_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_be_o   (mem_be_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i  (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Responder: acks after ack_wait idle cycles, logs each new request.
    always @(negedge clk_i) begin
        if (!mem_req_o) begin
            mem_ack_i = 1'b0;
            wait_cnt  = 0;
            new_req   = 1'b1;
        end else begin
            if (new_req) begin
                log_addr.push_back(mem_addr_o);
                log_be.push_back(mem_be_o);
                log_wdata.push_back(mem_wdata_o);
                log_we.push_back(mem_we_o);
                new_req = 1'b0;
            end
            if (acks_allowed > 0 && wait_cnt >= ack_wait) begin
                mem_ack_i    = 1'b1;
                mem_rdata_i  = mem_rd(mem_addr_o);
                acks_allowed = acks_allowed - 1;
                wait_cnt     = 0;
                new_req      = 1'b1;
            end else begin
                mem_ack_i = 1'b0;
                wait_cnt  = wait_cnt + 1;
            end
        end
    end

    // Issue one operation and wait (bounded) for done_o; lat counts the accept cycle as 1.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic seen,
                          output logic err, output logic [31:0] dat);
        log_addr.delete();
        log_be.delete();
        log_wdata.delete();
        log_we.delete();
        @(negedge clk_i);
        req_i    = 1'b1;
        we_i     = we;
        funct3_i = f3;
        addr_i   = addr;
        data_i   = wd;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        lat  = 1;
        seen = 1'b0;
        err  = 1'b0;
        dat  = 32'h0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            lat++;
            if (done_o) begin
                seen = 1'b1;
                err  = err_o;
                dat  = data_o;
            end
        end
        $display("op we=%0b f3=%03b addr=%08h wd=%08h -> done=%0b lat=%0d err=%0b data=%08h reqs=%0d",
                 we, f3, addr, wd, seen, lat, err, dat, log_addr.size());
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        n_cmp++; if ({done_o, err_o, mem_req_o, mem_we_o} !== 4'b0000) begin n_bad++;
            $display("FAIL reset_ctl got=%b exp=0000", {done_o, err_o, mem_req_o, mem_we_o}); end
        n_cmp++; if (data_o !== 32'h0) begin n_bad++; $display("FAIL reset_data got=%08h exp=00000000", data_o); end
        n_cmp++; if ({mem_addr_o, mem_be_o, mem_wdata_o} !== 68'h0) begin n_bad++;
            $display("FAIL reset_mem got=%08h/%b/%08h exp=0", mem_addr_o, mem_be_o, mem_wdata_o); end
        rst_ni = 1'b1;
        $display("reset checked");
    endtask

    task automatic test_lw_aligned();
        int lat; logic seen, err; logic [31:0] dat;
        mem[32'h10004] = 32'hDEADBEEF;
        run_op(1'b0, 3'b010, 32'h10004, 32'h0, lat, seen, err, dat);
        n_cmp++; if (!seen || lat != 3) begin n_bad++; $display("FAIL lw_latency got=%0d seen=%0b exp=3", lat, seen); end
        n_cmp++; if (err !== 1'b0 || dat !== 32'hDEADBEEF) begin n_bad++;
            $display("FAIL lw_data got=%08h err=%b exp=DEADBEEF err=0", dat, err); end
        n_cmp++; if (log_addr.size() != 1 || log_addr[0] !== 32'h10004 || log_be[0] !== 4'b1111 || log_we[0] !== 1'b0) begin
            n_bad++; $display("FAIL lw_req got=n%0d exp=n1 @00010004 be=1111 we=0", log_addr.size()); end
        @(negedge clk_i);
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL done_pulse got=%b exp=0", done_o); end
        repeat (3) @(negedge clk_i);
        n_cmp++; if (data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL data_hold got=%08h exp=DEADBEEF", data_o); end
    endtask

    task automatic test_split_loads();
        int lat; logic seen, err; logic [31:0] dat;
        mem[32'h10000] = 32'h80A1B2C3;
        mem[32'h10004] = 32'h55667712;
        run_op(1'b0, 3'b001, 32'h10003, 32'h0, lat, seen, err, dat);
        n_cmp++; if (!seen || lat != 4 || err !== 1'b0) begin n_bad++; $display("FAIL lh_split_lat got=%0d err=%b exp=4 err=0", lat, err); end
        n_cmp++; if (dat !== 32'h00001280) begin n_bad++; $display("FAIL lh_split_data got=%08h exp=00001280", dat); end
        n_cmp++; if (log_addr.size() != 2 || log_addr[0] !== 32'h10000 || log_be[0] !== 4'b1000 ||
                     log_addr[1] !== 32'h10004 || log_be[1] !== 4'b0001) begin
            n_bad++; $display("FAIL lh_split_reqs got=n%0d exp=n2 be 1000/0001", log_addr.size()); end
        run_op(1'b0, 3'b101, 32'h10003, 32'h0, lat, seen, err, dat);
        n_cmp++; if (!seen || dat !== 32'h00001280) begin n_bad++; $display("FAIL lhu_split got=%08h exp=00001280", dat); end
        run_op(1'b0, 3'b010, 32'h10001, 32'h0, lat, seen, err, dat);
        n_cmp++; if (!seen || lat != 4 || dat !== 32'h1280A1B2) begin n_bad++;
            $display("FAIL lw_mis got=%08h lat=%0d exp=1280A1B2 lat=4", dat, lat); end
        n_cmp++; if (log_be.size() != 2 || log_be[0] !== 4'b1110 || log_be[1] !== 4'b0001) begin
            n_bad++; $display("FAIL lw_mis_be got=n%0d exp=1110/0001", log_be.size()); end
    endtask

    task automatic test_subword_loads();
        int lat; logic seen, err; logic [31:0] dat;
        mem[32'h10000] = 32'h80A1B2C3;
        run_op(1'b0, 3'b000, 32'h10003, 32'h0, lat, seen, err, dat);
        n_cmp++; if (!seen || lat != 3 || dat !== 32'hFFFFFF80) begin n_bad++;
            $display("FAIL lb got=%08h lat=%0d exp=FFFFFF80 lat=3", dat, lat); end
        n_cmp++; if (log_be.size() != 1 || log_be[0] !== 4'b1000) begin n_bad++; $display("FAIL lb_be got=n%0d exp=1000", log_be.size()); end
        run_op(1'b0, 3'b100, 32'h10003, 32'h0, lat, seen, err, dat);
        n_cmp++; if (!seen || dat !== 32'h00000080) begin n_bad++; $display("FAIL lbu got=%08h exp=00000080", dat); end
        run_op(1'b0, 3'b001, 32'h10002, 32'h0, lat, seen, err, dat);
        n_cmp++; if (!seen || dat !== 32'hFFFF80A1) begin n_bad++; $display("FAIL lh got=%08h exp=FFFF80A1", dat); end
        n_cmp++; if (log_be.size() != 1 || log_be[0] !== 4'b1100) begin n_bad++; $display("FAIL lh_be got=n%0d exp=1100", log_be.size()); end
        run_op(1'b0, 3'b101, 32'h10002, 32'h0, lat, seen, err, dat);
        n_cmp++; if (!seen || dat !== 32'h000080A1) begin n_bad++; $display("FAIL lhu got=%08h exp=000080A1", dat); end
    endtask

    task automatic test_stores();
        int lat; logic seen, err; logic [31:0] dat;
        run_op(1'b1, 3'b010, 32'h10002, 32'h11223344, lat, seen, err, dat);
        n_cmp++; if (!seen || lat != 4 || err !== 1'b0 || dat !== 32'h0) begin n_bad++;
            $display("FAIL sw_done got=lat%0d err=%b data=%08h exp=lat4 err0 data0", lat, err, dat); end
        n_cmp++; if (log_addr.size() != 2 || log_addr[0] !== 32'h10000 || log_be[0] !== 4'b1100 ||
                     log_wdata[0] !== 32'h33440000 || log_we[0] !== 1'b1) begin
            n_bad++; $display("FAIL sw_req0 got=n%0d exp=@00010000 be1100 33440000 we1", log_addr.size()); end
        n_cmp++; if (log_addr.size() != 2 || log_addr[1] !== 32'h10004 || log_be[1] !== 4'b0011 ||
                     log_wdata[1] !== 32'h00001122 || log_we[1] !== 1'b1) begin
            n_bad++; $display("FAIL sw_req1 got=n%0d exp=@00010004 be0011 00001122 we1", log_addr.size()); end
        run_op(1'b1, 3'b000, 32'h10001, 32'hAABBCCDD, lat, seen, err, dat);
        n_cmp++; if (!seen || lat != 3 || log_addr.size() != 1 || log_be[0] !== 4'b0010 || log_wdata[0] !== 32'hBBCCDD00) begin
            n_bad++; $display("FAIL sb got=lat%0d n%0d exp=lat3 be0010 BBCCDD00", lat, log_addr.size()); end
    endtask

    task automatic test_illegal();
        int lat; logic seen, err; logic [31:0] dat;
        run_op(1'b0, 3'b011, 32'h10004, 32'h0, lat, seen, err, dat);
        n_cmp++; if (!seen || lat != 2 || err !== 1'b1 || dat !== 32'h0) begin n_bad++;
            $display("FAIL illegal_011 got=lat%0d err=%b data=%08h exp=lat2 err1 data0", lat, err, dat); end
        n_cmp++; if (log_addr.size() != 0) begin n_bad++; $display("FAIL illegal_noreq got=%0d exp=0", log_addr.size()); end
        run_op(1'b1, 3'b100, 32'h10004, 32'h12345678, lat, seen, err, dat);
        n_cmp++; if (!seen || lat != 2 || err !== 1'b1 || log_addr.size() != 0) begin n_bad++;
            $display("FAIL illegal_sbu got=lat%0d err=%b n%0d exp=lat2 err1 n0", lat, err, log_addr.size()); end
    endtask

    task automatic test_wrap_timeout();
        int lat; logic seen, err; logic [31:0] dat;
        acks_allowed = 1;
        run_op(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, lat, seen, err, dat);
        acks_allowed = 1000000;
        n_cmp++; if (log_addr.size() != 2 || log_addr[0] !== 32'hFFFFFFFC || log_be[0] !== 4'b1100 ||
                     log_addr[1] !== 32'h00000000 || log_be[1] !== 4'b0011) begin
            n_bad++; $display("FAIL wrap_reqs got=n%0d exp=@FFFFFFFC/1100 @00000000/0011", log_addr.size()); end
        n_cmp++; if (!seen || err !== 1'b1 || dat !== 32'h0) begin n_bad++;
            $display("FAIL timeout got=done%0b err=%b data=%08h exp=done1 err1 data0", seen, err, dat); end
        n_cmp++; if (lat != 19) begin n_bad++; $display("FAIL timeout_lat got=%0d exp=19", lat); end
    endtask

    task automatic test_wait_states();
        int lat; logic seen, err; logic [31:0] dat;
        mem[32'h10000] = 32'h80A1B2C3;
        mem[32'h10004] = 32'h55667712;
        ack_wait = 2;
        run_op(1'b0, 3'b010, 32'h10004, 32'h0, lat, seen, err, dat);
        n_cmp++; if (!seen || lat != 5 || dat !== 32'h55667712) begin n_bad++;
            $display("FAIL wait_lw got=lat%0d %08h exp=lat5 55667712", lat, dat); end
        ack_wait = 1;
        run_op(1'b0, 3'b001, 32'h10003, 32'h0, lat, seen, err, dat);
        n_cmp++; if (!seen || lat != 6 || dat !== 32'h00001280 || err !== 1'b0) begin n_bad++;
            $display("FAIL wait_lh got=lat%0d %08h err=%b exp=lat6 00001280 err0", lat, dat, err); end
        ack_wait = 0;
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        mem[32'h10004] = 32'hDEADBEEF;
        log_addr.delete(); log_be.delete(); log_wdata.delete(); log_we.delete();
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h10004; data_i = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (i == 0) begin
                n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL busy_ready got=%b exp=0", ready_o); end
            end
            if (done_o) dones++;
        end
        req_i = 1'b0;
        $display("back_to_back dones=%0d reqs=%0d", dones, log_addr.size());
        n_cmp++; if (dones != 2 || log_addr.size() != 2) begin n_bad++;
            $display("FAIL back_to_back got=dones%0d reqs%0d exp=2/2", dones, log_addr.size()); end
        n_cmp++; if (data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL b2b_data got=%08h exp=DEADBEEF", data_o); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        mem[32'h10000] = 32'h80A1B2C3;
        acks_allowed = 1;
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b001; addr_i = 32'h10003; data_i = 32'h0;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        @(negedge clk_i);   // ACC0, acked
        @(negedge clk_i);   // ACC1, waiting
        n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10004) begin n_bad++;
            $display("FAIL mid_acc1 got=req%b @%08h exp=req1 @00010004", mem_req_o, mem_addr_o); end
        rst_ni = 1'b0;
        @(negedge clk_i);
        n_cmp++; if (ready_o !== 1'b1 || mem_req_o !== 1'b0 || done_o !== 1'b0 || data_o !== 32'h0) begin n_bad++;
            $display("FAIL mid_reset got=rdy%b req%b done%b data=%08h exp=1 0 0 0", ready_o, mem_req_o, done_o, data_o); end
        rst_ni = 1'b1;
        acks_allowed = 1000000;
        repeat (6) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        $display("reset_mid dones_after=%0d", dones);
        n_cmp++; if (dones != 0 || ready_o !== 1'b1) begin n_bad++;
            $display("FAIL mid_no_done got=dones%0d rdy%b exp=0 rdy1", dones, ready_o); end
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_i       = 1'b0;
        we_i        = 1'b0;
        funct3_i    = 3'b000;
        addr_i      = 32'h0;
        data_i      = 32'h0;
        mem_rdata_i = 32'h0;
        mem_ack_i   = 1'b0;
        test_reset();
        test_lw_aligned();
        test_split_loads();
        test_subword_loads();
        test_stores();
        test_illegal();
        test_wrap_timeout();
        test_wait_states();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
